mac_table_scheduler: RTL and testbench

MAC_TABLE_SCHEDULER -- requirements
Module: mac_table_scheduler

---
 rtl/mac_table_scheduler_if.sv | 41 ++++
 rtl/mac_table_scheduler.sv | 177 +++++++++++++++++
 tb/tb_mac_table_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_table_scheduler_if.sv
// mac_table_scheduler_if
// Groups the requester-side and MAC-table-side signals of mac_table_scheduler.
//   slave  modport: the scheduler (samples requests/table results, drives strobes).
//   master modport: the requesting ports plus the MAC table.
// Signals:
//   i_req, i_req_learn   per-port request and op type (1 = learn SA, 0 = look up DA)
//   i_mac                per-port MAC, port p at bits [48p+47:48p]
//   o_ack                one-hot accept pulse
//   o_tbl_we, o_tbl_rd   table write / read strobes
//   o_tbl_port_num/mac   source port and address presented to the table
//   i_tbl_port_num/hit   table result, LOOKUP_LAT cycles after o_tbl_rd
//   o_rsp_val/mask       one-hot lookup response and egress mask
//   o_busy               scheduler not idle
interface mac_table_scheduler_if #(
  parameter int unsigned NPORTS = 4,
  parameter int unsigned PW     = $clog2(NPORTS)
);
  logic [NPORTS-1:0]    i_req;
  logic [NPORTS-1:0]    i_req_learn;
  logic [NPORTS*48-1:0] i_mac;
  logic [NPORTS-1:0]    o_ack;
  logic                 o_tbl_we;
  logic                 o_tbl_rd;
  logic [PW-1:0]        o_tbl_port_num;
  logic [47:0]          o_tbl_mac;
  logic [PW-1:0]        i_tbl_port_num;
  logic                 i_tbl_hit;
  logic [NPORTS-1:0]    o_rsp_val;
  logic [NPORTS-1:0]    o_rsp_mask;
  logic                 o_busy;

  modport slave (
    input  i_req, i_req_learn, i_mac, i_tbl_port_num, i_tbl_hit,
    output o_ack, o_tbl_we, o_tbl_rd, o_tbl_port_num, o_tbl_mac, o_rsp_val, o_rsp_mask, o_busy
  );

  modport master (
    output i_req, i_req_learn, i_mac, i_tbl_port_num, i_tbl_hit,
    input  o_ack, o_tbl_we, o_tbl_rd, o_tbl_port_num, o_tbl_mac, o_rsp_val, o_rsp_mask, o_busy
  );
endinterface

// File: rtl/mac_table_scheduler.sv
// mac_table_scheduler
// Round-robin arbiter that shares one MAC table between NPORTS switch ports.
// Learn requests write the source address (multicast SAs are acknowledged but not
// written); lookup requests read the table and return an egress mask to the
// requesting port after the fixed table latency. One table operation at a time.
// Ports:
//   iclk  clock, rising edge
//   irst  synchronous active-high reset
//   bus   mac_table_scheduler_if.slave (requests, table strobes/results, responses)
// All outputs are registered.
module mac_table_scheduler #(
  parameter int unsigned NPORTS     = 4,
  parameter int unsigned LOOKUP_LAT = 2,
  parameter int unsigned PW         = $clog2(NPORTS)
) (
  input logic                  iclk,
  input logic                  irst,
  mac_table_scheduler_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [NPORTS-1:0] OneLsb   = NPORTS'(1);
  localparam logic [2:0]        LastCnt  = 3'(LOOKUP_LAT - 1);
  localparam logic [PW-1:0]     LastPort = PW'(NPORTS - 1);

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     gnt_q, gnt_d;
  logic              learn_q, learn_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [NPORTS-1:0] ack_q, ack_d;
  logic              we_q, we_d;
  logic              rd_q, rd_d;
  logic [PW-1:0]     tport_q, tport_d;
  logic [47:0]       tmac_q, tmac_d;
  logic [NPORTS-1:0] rsp_val_q, rsp_val_d;
  logic [NPORTS-1:0] rsp_mask_q, rsp_mask_d;
  logic              busy_q, busy_d;

  logic              arb_found;
  logic [PW-1:0]     arb_idx;
  logic              arb_learn;
  logic [47:0]       arb_mac;
  logic [NPORTS-1:0] src_oh, res_oh, lookup_mask;

  // First requesting port at or after the pointer, wrapping to port 0.
  always_comb begin : arbiter
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int unsigned k = 0; k < NPORTS; k++) begin
      for (int unsigned p = 0; p < NPORTS; p++) begin
        if (!arb_found && bus.i_req[p] && (p == (32'(ptr_q) + k) % NPORTS)) begin
          arb_found = 1'b1;
          arb_idx   = PW'(p);
        end
      end
    end
  end

  always_comb begin : arb_mux
    arb_learn = 1'b0;
    arb_mac   = '0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      if (arb_idx == PW'(p)) begin
        arb_learn = bus.i_req_learn[p];
        arb_mac   = bus.i_mac[p*48 +: 48];
      end
    end
  end

  // Egress mask: forward to the hit port, filter when it is the source, flood on miss.
  assign src_oh      = OneLsb << gnt_q;
  assign res_oh      = OneLsb << bus.i_tbl_port_num;
  assign lookup_mask = !bus.i_tbl_hit                  ? ~src_oh :
                       (bus.i_tbl_port_num == gnt_q)   ? '0      : res_oh;

  always_comb begin : next_state
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    learn_d    = learn_q;
    cnt_d      = cnt_q;
    ack_d      = '0;
    we_d       = 1'b0;
    rd_d       = 1'b0;
    tport_d    = tport_q;
    tmac_d     = tmac_q;
    rsp_val_d  = '0;
    rsp_mask_d = rsp_mask_q;

    unique case (state_q)
      StIdle: begin
        if (arb_found) begin
          state_d = StIssue;
          gnt_d   = arb_idx;
          learn_d = arb_learn;
          ptr_d   = (arb_idx == LastPort) ? '0 : arb_idx + 1'b1;
          // Outputs are registered, so the ISSUE-cycle strobes are loaded here.
          ack_d   = OneLsb << arb_idx;
          tport_d = arb_idx;
          tmac_d  = arb_mac;
          we_d    = arb_learn & ~arb_mac[40];  // I/G bit set: never learn a group SA
          rd_d    = ~arb_learn;
        end
      end
      StIssue: begin
        if (learn_q) begin
          state_d = StIdle;
        end else begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      StWait: begin
        // Count LOOKUP_LAT cycles from the read strobe; the last one carries the result.
        if (cnt_q == LastCnt) begin
          state_d    = StResp;
          rsp_val_d  = src_oh;
          rsp_mask_d = lookup_mask;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      gnt_q      <= '0;
      learn_q    <= 1'b0;
      cnt_q      <= '0;
      ack_q      <= '0;
      we_q       <= 1'b0;
      rd_q       <= 1'b0;
      tport_q    <= '0;
      tmac_q     <= '0;
      rsp_val_q  <= '0;
      rsp_mask_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      learn_q    <= learn_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
      tport_q    <= tport_d;
      tmac_q     <= tmac_d;
      rsp_val_q  <= rsp_val_d;
      rsp_mask_q <= rsp_mask_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.o_ack          = ack_q;
  assign bus.o_tbl_we       = we_q;
  assign bus.o_tbl_rd       = rd_q;
  assign bus.o_tbl_port_num = tport_q;
  assign bus.o_tbl_mac      = tmac_q;
  assign bus.o_rsp_val      = rsp_val_q;
  assign bus.o_rsp_mask     = rsp_mask_q;
  assign bus.o_busy         = busy_q;

endmodule

// File: tb/tb_mac_table_scheduler.sv
// tb_mac_table_scheduler
// Drives directed and random traffic into mac_table_scheduler. A timeline model
// records, per cycle number, what every output must show; one compare process
// checks the DUT against it on every cycle after the first reset.
`timescale 1ns/1ps
module tb_mac_table_scheduler;
  localparam int unsigned NPORTS = 4;
  localparam int unsigned LAT    = 2;
  localparam int unsigned PW     = 2;
  localparam int          MAXC   = 6000;

  logic iclk = 1'b0;
  logic irst;
  always #5 iclk = ~iclk;

  mac_table_scheduler_if #(.NPORTS(NPORTS), .PW(PW)) bus ();

  mac_table_scheduler #(.NPORTS(NPORTS), .LOOKUP_LAT(LAT), .PW(PW)) dut (
    .iclk(iclk),
    .irst(irst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge iclk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Expected outputs indexed by cycle number.
  bit [NPORTS-1:0] e_ack  [MAXC];
  bit [NPORTS-1:0] e_rsp  [MAXC];
  bit [NPORTS-1:0] e_mask [MAXC];
  bit              e_we   [MAXC];
  bit              e_rd   [MAXC];
  bit              e_busy [MAXC];
  bit              e_rst  [MAXC];
  bit [PW-1:0]     e_port [MAXC];
  bit [47:0]       e_mac  [MAXC];
  // Table answers planned at grant time, driven on the result cycle.
  bit              p_valid[MAXC];
  bit              p_hit  [MAXC];
  bit [PW-1:0]     p_port [MAXC];

  int   ptr       = 0;
  int   free_c    = 0;
  int   cmp_start = MAXC;
  int   last_c    = 0;
  int   grants[$];
  bit   force_tbl = 1'b0;
  bit   f_hit     = 1'b0;
  bit [PW-1:0] f_port = '0;

  bit [NPORTS-1:0] req_v   = '0;
  bit [NPORTS-1:0] learn_v = '0;
  bit [47:0]       mac_v [NPORTS];
  bit              rst_v   = 1'b1;
  int              mode    = 0;  // 0 directed, 1 all ports continuous, 2 random

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  task automatic model_step(int c);
    int              g;
    bit              found;
    bit              hit;
    bit [PW-1:0]     rp;
    bit [NPORTS-1:0] src;
    bit [47:0]       m;
    if (c + int'(LAT) + 8 >= MAXC) return;
    if (rst_v) begin
      ptr    = 0;
      free_c = c + 1;
      for (int k = c + 1; k <= c + int'(LAT) + 4; k++) begin
        e_ack[k] = '0; e_rsp[k] = '0; e_mask[k] = '0; e_we[k] = 0; e_rd[k] = 0;
        e_busy[k] = 0; e_port[k] = '0; e_mac[k] = '0;
      end
      e_rst[c+1] = 1'b1;
      if (cmp_start > c + 1) cmp_start = c + 1;
      return;
    end
    if (c < free_c || req_v == '0) return;
    found = 1'b0;
    g     = 0;
    for (int k = 0; k < int'(NPORTS); k++) begin
      int p;
      p = (ptr + k) % NPORTS;
      if (!found && req_v[p]) begin
        found = 1'b1;
        g     = p;
      end
    end
    grants.push_back(g);
    ptr = (g + 1) % NPORTS;
    m   = mac_v[g];
    src = 1 << g;
    e_ack[c+1]  = src;
    e_busy[c+1] = 1'b1;
    e_port[c+1] = PW'(g);
    e_mac[c+1]  = m;
    if (learn_v[g]) begin
      e_we[c+1] = ~m[40];
      free_c    = c + 2;
    end else begin
      e_rd[c+1] = 1'b1;
      if (force_tbl) begin
        hit = f_hit;
        rp  = f_port;
      end else begin
        hit = 1'($urandom_range(0, 1));
        rp  = ($urandom_range(0, 3) == 0) ? PW'(g) : PW'($urandom_range(0, NPORTS - 1));
      end
      p_valid[c+1+LAT] = 1'b1;
      p_hit[c+1+LAT]   = hit;
      p_port[c+1+LAT]  = rp;
      for (int k = c + 2; k <= c + 2 + int'(LAT); k++) e_busy[k] = 1'b1;
      e_rsp[c+2+LAT] = src;
      if (!hit)                e_mask[c+2+LAT] = ~src;
      else if (int'(rp) == g)  e_mask[c+2+LAT] = '0;
      else                     e_mask[c+2+LAT] = 1 << rp;
      free_c = c + 3 + int'(LAT);
    end
  endtask

  // One cycle of stimulus: requesters react to o_ack, new traffic, table, model.
  task automatic tick();
    bit [NPORTS-1:0] ack_now;
    bit [63:0]       r64;
    @(negedge iclk);
    ack_now = bus.o_ack;
    req_v   = req_v & ~ack_now;
    if (mode == 1) begin
      req_v   = ~ack_now;
      learn_v = '1;
      for (int p = 0; p < int'(NPORTS); p++) mac_v[p] = {8'h02, 40'(p)};
    end else if (mode == 2) begin
      for (int p = 0; p < int'(NPORTS); p++) begin
        if (!req_v[p] && !ack_now[p] && $urandom_range(0, 3) == 0) begin
          r64        = {$urandom, $urandom};
          req_v[p]   = 1'b1;
          learn_v[p] = 1'($urandom_range(0, 1));
          mac_v[p]   = r64[47:0];
        end
      end
      rst_v = ($urandom_range(0, 299) == 0);
    end
    bus.i_req       = req_v;
    bus.i_req_learn = learn_v;
    for (int p = 0; p < int'(NPORTS); p++) bus.i_mac[p*48 +: 48] = mac_v[p];
    if (p_valid[cyc]) begin
      bus.i_tbl_hit      = p_hit[cyc];
      bus.i_tbl_port_num = p_port[cyc];
    end else begin
      bus.i_tbl_hit      = 1'($urandom_range(0, 1));
      bus.i_tbl_port_num = PW'($urandom_range(0, NPORTS - 1));
    end
    irst   = rst_v;
    last_c = cyc;
    model_step(cyc);
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Compare process: every cycle after the first reset.
  always @(negedge iclk) begin
    if (cyc >= cmp_start && cyc < MAXC) begin
      chk("ack",     bus.o_ack,     e_ack[cyc]);
      chk("tbl_we",  bus.o_tbl_we,  e_we[cyc]);
      chk("tbl_rd",  bus.o_tbl_rd,  e_rd[cyc]);
      chk("rsp_val", bus.o_rsp_val, e_rsp[cyc]);
      chk("busy",    bus.o_busy,    e_busy[cyc]);
      if (e_ack[cyc] != '0 || e_rst[cyc]) begin
        chk("tbl_port", bus.o_tbl_port_num, e_port[cyc]);
        chk("tbl_mac",  bus.o_tbl_mac,      e_mac[cyc]);
      end
      if (e_rsp[cyc] != '0 || e_rst[cyc]) chk("rsp_mask", bus.o_rsp_mask, e_mask[cyc]);
    end
  end

  initial begin
    int g;
    irst               = 1'b1;
    bus.i_req          = '0;
    bus.i_req_learn    = '0;
    bus.i_mac          = '0;
    bus.i_tbl_hit      = 1'b0;
    bus.i_tbl_port_num = '0;
    for (int p = 0; p < int'(NPORTS); p++) mac_v[p] = '0;

    rst_v = 1'b1;
    ticks(3);
    rst_v = 1'b0;
    ticks(2);

    // Learn on port 2.
    req_v[2] = 1'b1; learn_v[2] = 1'b1; mac_v[2] = 48'h001122334455;
    tick();
    g = last_c;
    chk("learn_model_ack", e_ack[g+1], 4'b0100);
    chk("learn_model_mac", e_mac[g+1], 48'h001122334455);
    tick();
    chk("learn_ack",  bus.o_ack,          4'b0100);
    chk("learn_we",   bus.o_tbl_we,       1'b1);
    chk("learn_port", bus.o_tbl_port_num, 2'd2);
    chk("learn_mac",  bus.o_tbl_mac,      48'h001122334455);
    tick();
    chk("learn_busy_low", bus.o_busy, 1'b0);
    ticks(2);

    // Lookup on port 1, table hit on port 3.
    force_tbl = 1'b1; f_hit = 1'b1; f_port = 2'd3;
    req_v[1] = 1'b1; learn_v[1] = 1'b0; mac_v[1] = 48'h0a0b0c0d0e0f;
    tick();
    g = last_c;
    chk("lk_hit_model_mask", e_mask[g+2+LAT], 4'b1000);
    ticks(2 + LAT);
    chk("lk_hit_rsp_val", bus.o_rsp_val,  4'b0010);
    chk("lk_hit_mask",    bus.o_rsp_mask, 4'b1000);
    ticks(2);

    // Lookup on port 0 with a miss: flood.
    f_hit = 1'b0; f_port = 2'd1;
    req_v[0] = 1'b1; learn_v[0] = 1'b0; mac_v[0] = 48'h112233445566;
    tick();
    g = last_c;
    chk("lk_miss_model_mask", e_mask[g+2+LAT], 4'b1110);
    ticks(2 + LAT);
    chk("lk_miss_mask", bus.o_rsp_mask, 4'b1110);
    ticks(2);

    // Lookup on port 3 hitting port 3: filter.
    f_hit = 1'b1; f_port = 2'd3;
    req_v[3] = 1'b1; learn_v[3] = 1'b0; mac_v[3] = 48'h223344556677;
    tick();
    g = last_c;
    chk("lk_filter_model_mask", e_mask[g+2+LAT], 4'b0000);
    ticks(2 + LAT);
    chk("lk_filter_rsp_val", bus.o_rsp_val,  4'b1000);
    chk("lk_filter_mask",    bus.o_rsp_mask, 4'b0000);
    ticks(2);

    // Multicast SA learn on port 1: acknowledged, not written.
    req_v[1] = 1'b1; learn_v[1] = 1'b1; mac_v[1] = 48'h01005e000001;
    tick();
    tick();
    chk("mcast_ack", bus.o_ack,    4'b0010);
    chk("mcast_we",  bus.o_tbl_we, 1'b0);
    ticks(3);

    // Reset during WAIT of a port-2 lookup.
    f_hit = 1'b1; f_port = 2'd0;
    req_v[2] = 1'b1; learn_v[2] = 1'b0; mac_v[2] = 48'h334455667788;
    tick();          // grant
    tick();          // ISSUE
    rst_v = 1'b1;
    tick();          // first WAIT cycle, reset sampled at its end
    rst_v = 1'b0;
    req_v = 4'b1010; learn_v = 4'b1010;
    mac_v[1] = 48'h020000000001; mac_v[3] = 48'h020000000003;
    tick();
    chk("rst_busy",     bus.o_busy,     1'b0);
    chk("rst_rd",       bus.o_tbl_rd,   1'b0);
    chk("rst_rsp_val",  bus.o_rsp_val,  4'b0000);
    chk("rst_tbl_mac",  bus.o_tbl_mac,  48'h0);
    chk("rst_first_grant", grants[grants.size()-1], 1);
    tick();
    chk("rst_no_rsp",    bus.o_rsp_val, 4'b0000);
    chk("rst_grant_ack", bus.o_ack,     4'b0010);
    ticks(6);

    // All four ports requesting continuously from reset.
    rst_v = 1'b1;
    tick();
    rst_v = 1'b0;
    grants.delete();
    mode = 1;
    ticks(12);
    mode = 0;
    ticks(12);
    chk("rr_count", grants.size() >= 5, 1'b1);
    for (int i = 0; i < 5; i++)
      chk("rr_order", (i < grants.size()) ? grants[i] : -1, i % 4);

    // Random traffic with occasional resets.
    force_tbl = 1'b0;
    mode = 2;
    ticks(3000);
    mode  = 0;
    rst_v = 1'b0;
    ticks(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
